// File: rtl/gray_counter.sv
// gray_counter: registered up/down binary counter with Gray-coded view, parallel load and wrap pulse
module gray_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic         load_is_gray,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] bin_count,
  output logic [N-1:0] gray_count,
  output logic         wrap
);
  logic [N-1:0] bin_q, bin_d, gray_q, gray_d, load_bin;
  logic         wrap_q, wrap_d;
  always_comb begin
    load_bin = load_val;
    for (int i = N - 2; i >= 0; i--) load_bin[i] = load_bin[i+1] ^ load_val[i];
    bin_d  = load ? (load_is_gray ? load_bin : load_val) :
             en   ? (up_dn ? bin_q + N'(1) : bin_q - N'(1)) : bin_q;
    wrap_d = !load && en && (up_dn ? &bin_q : ~|bin_q);
    gray_d = bin_d ^ (bin_d >> 1);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end
  assign bin_count  = bin_q;
  assign gray_count = gray_q;
  assign wrap       = wrap_q;
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed and random checks of gray_counter against an arithmetic reference model
module tb_gray_counter;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0, en = 1'b0, up_dn = 1'b0, load = 1'b0, load_is_gray = 1'b0;
  logic [7:0] load_val = '0;
  logic [7:0] bin_count, gray_count;
  logic       wrap;
  int         errs = 0, checks = 0;
  int         m_bin = 0;
  bit         m_wrap = 0;
  logic [7:0] prev_gray;

  gray_counter #(.N(8)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
    .load_is_gray(load_is_gray), .load_val(load_val),
    .bin_count(bin_count), .gray_count(gray_count), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Decode a Gray word by searching for the binary value whose Gray code matches it
  function automatic int g2b(input int g);
    for (int b = 0; b < 256; b++) if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rn, input bit e, input bit up, input bit ld, input bit lg, input logic [7:0] lv);
    int nxt;
    reset_n = rn; en = e; up_dn = up; load = ld; load_is_gray = lg; load_val = lv;
    prev_gray = gray_count;
    @(posedge clk);
    if (!rn) begin
      m_bin = 0; m_wrap = 0;
    end else if (ld) begin
      m_bin = lg ? g2b(int'(lv)) : int'(lv); m_wrap = 0;
    end else if (e) begin
      nxt = up ? m_bin + 1 : m_bin - 1;
      m_wrap = (nxt > 255) || (nxt < 0);
      m_bin = (nxt + 256) % 256;
    end else m_wrap = 0;
    #1;
    chk("bin", 32'(bin_count), 32'(m_bin));
    chk("gray", 32'(gray_count), 32'(m_bin ^ (m_bin >> 1)));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    if (rn && !ld && e) chk("gray_one_bit", 32'($countones(prev_gray ^ gray_count)), 32'd1);
  endtask

  initial begin
    step(0, 1, 1, 1, 0, 8'h55);
    step(0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 8'h00);
    chk("up5_bin", 32'(bin_count), 32'h05);
    chk("up5_gray", 32'(gray_count), 32'h07);
    step(1, 0, 1, 1, 0, 8'hFE);
    step(1, 1, 1, 0, 0, 8'h00);
    chk("upwrap_gray_ff", 32'(gray_count), 32'h80);
    step(1, 1, 1, 0, 0, 8'h00);
    chk("upwrap_flag", 32'(wrap), 32'd1);
    step(1, 0, 1, 0, 0, 8'h00);
    chk("upwrap_pulse_end", 32'(wrap), 32'd0);
    step(0, 0, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 8'h00);
    chk("dnwrap_gray", 32'(gray_count), 32'h80);
    chk("dnwrap_flag", 32'(wrap), 32'd1);
    step(1, 1, 0, 0, 0, 8'h00);
    chk("dn_fe_gray", 32'(gray_count), 32'h81);
    step(1, 0, 0, 1, 0, 8'hA5);
    chk("ld_bin_gray", 32'(gray_count), 32'hF7);
    step(1, 0, 0, 1, 1, 8'hF7);
    chk("ld_gray_bin", 32'(bin_count), 32'hA5);
    step(1, 0, 0, 1, 0, 8'hFF);
    step(1, 1, 1, 1, 0, 8'h10);
    chk("ld_en_bin", 32'(bin_count), 32'h10);
    chk("ld_en_wrap", 32'(wrap), 32'd0);
    step(1, 0, 0, 1, 0, 8'h40);
    for (int i = 0; i < 3; i++) step(1, 0, i[0], 0, 0, 8'h00);
    step(1, 1, 1, 0, 0, 8'h00);
    step(1, 1, 1, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 8'h00);
    step(1, 1, 0, 0, 0, 8'h00);
    chk("flip_bin", 32'(bin_count), 32'h40);
    step(1, 0, 0, 1, 0, 8'h36);
    step(1, 1, 1, 0, 0, 8'h00);
    step(0, 1, 1, 1, 0, 8'hCC);
    chk("midreset_bin", 32'(bin_count), 32'h00);
    step(1, 1, 1, 0, 0, 8'h00);
    chk("resume_bin", 32'(bin_count), 32'h01);
    for (int i = 0; i < 600; i++) begin
      logic [7:0] lv;
      lv = 8'($urandom);
      if ($urandom_range(3, 0) == 0) lv = ($urandom_range(1, 0) == 1) ? 8'hFF : 8'h00;
      step($urandom_range(49, 0) != 0, $urandom_range(3, 0) != 0, 1'($urandom),
           $urandom_range(15, 0) == 0, 1'($urandom), lv);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
